// File: rtl/stack_rpn_sequencer.sv
// stack_rpn_sequencer
//   Upstream command sequencer for a 5-entry, 4-bit stack unit. It accepts
//   8-bit RPN instructions and translates each one into the stack's
//   COMMAND / INDEX / IO_DATA bus protocol. The block keeps its own occupancy
//   count, so overflow, underflow and bad indexes are reported as errors and
//   never reach the stack.
//
// Ports
//   CLK, RESET       clock; synchronous active-high reset
//   IN_VALID/READY   instruction handshake; IN_INSTR = {opcode, operand}
//   OUT_VALID/READY  result handshake; OUT_DATA is held while OUT_VALID
//   ERR, ERR_CODE    one-cycle error pulse; code (01 ovf, 10 unf, 11 illegal)
//   DEPTH            current stack occupancy 0..5
//   STK_COMMAND      00 nop, 01 push, 10 pop, 11 peek
//   STK_INDEX        peek index, 0 = top
//   STK_DATA         shared data bus, driven here only during a push
//   STK_RESET        stack reset (RESET or CLEAR)
module stack_rpn_sequencer (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       IN_VALID,
  input  logic [7:0] IN_INSTR,
  output logic       IN_READY,
  output logic       OUT_VALID,
  output logic [3:0] OUT_DATA,
  input  logic       OUT_READY,
  output logic       ERR,
  output logic [1:0] ERR_CODE,
  output logic [2:0] DEPTH,
  output logic [1:0] STK_COMMAND,
  output logic [2:0] STK_INDEX,
  inout  wire  [3:0] STK_DATA,
  output logic       STK_RESET
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PUSH     = 3'd1;
  localparam logic [2:0] S_POP_ISS  = 3'd2;
  localparam logic [2:0] S_POP_DRN  = 3'd3;
  localparam logic [2:0] S_PEEK_ISS = 3'd4;
  localparam logic [2:0] S_PEEK_DRN = 3'd5;
  localparam logic [2:0] S_EMIT     = 3'd6;
  localparam logic [2:0] S_CLR      = 3'd7;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_PUSH  = 4'd1;
  localparam logic [3:0] OP_POP   = 4'd2;
  localparam logic [3:0] OP_PEEK  = 4'd3;
  localparam logic [3:0] OP_ADD   = 4'd4;
  localparam logic [3:0] OP_SUB   = 4'd5;
  localparam logic [3:0] OP_DUP   = 4'd6;
  localparam logic [3:0] OP_CLEAR = 4'd7;

  localparam logic [1:0] E_NONE = 2'b00;
  localparam logic [1:0] E_OVF  = 2'b01;
  localparam logic [1:0] E_UNF  = 2'b10;
  localparam logic [1:0] E_ILL  = 2'b11;

  logic [2:0] state;
  logic [3:0] op;       // latched opcode
  logic [3:0] imm;      // latched operand
  logic [2:0] idx;      // latched peek index (0 for DUP)
  logic       second;   // ADD/SUB: first operand already popped
  logic [3:0] a_q;      // first popped operand (top of stack)
  logic [3:0] rd_q;     // falling-edge capture of the stack read bus
  logic [3:0] push_data;
  logic [3:0] opc;
  logic [1:0] chk_code;
  logic       accept;

  assign opc    = IN_INSTR[7:4];
  assign accept = IN_VALID && IN_READY;

  // Legality against the current depth; E_NONE means the instruction runs.
  always_comb begin
    chk_code = E_NONE;
    case (opc)
      OP_NOP, OP_CLEAR: chk_code = E_NONE;
      OP_PUSH: if (DEPTH == 3'd5) chk_code = E_OVF;
      OP_POP:  if (DEPTH == 3'd0) chk_code = E_UNF;
      OP_PEEK: begin
        if (DEPTH == 3'd0)                chk_code = E_UNF;
        else if (IN_INSTR[2:0] >= DEPTH)  chk_code = E_ILL;
      end
      OP_ADD, OP_SUB: if (DEPTH < 3'd2) chk_code = E_UNF;
      OP_DUP: begin
        if (DEPTH == 3'd0)      chk_code = E_UNF;
        else if (DEPTH == 3'd5) chk_code = E_OVF;
      end
      default: chk_code = E_ILL;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= S_IDLE;
      DEPTH    <= 3'd0;
      ERR      <= 1'b0;
      ERR_CODE <= E_NONE;
      OUT_DATA <= 4'd0;
      op       <= OP_NOP;
      imm      <= 4'd0;
      idx      <= 3'd0;
      second   <= 1'b0;
      a_q      <= 4'd0;
    end else begin
      ERR <= 1'b0;
      case (state)
        S_IDLE: if (accept) begin
          op     <= opc;
          imm    <= IN_INSTR[3:0];
          idx    <= (opc == OP_PEEK) ? IN_INSTR[2:0] : 3'd0;
          second <= 1'b0;
          if (chk_code != E_NONE) begin
            ERR      <= 1'b1;
            ERR_CODE <= chk_code;
          end else begin
            case (opc)
              OP_PUSH:                 state <= S_PUSH;
              OP_POP, OP_ADD, OP_SUB:  state <= S_POP_ISS;
              OP_PEEK, OP_DUP:         state <= S_PEEK_ISS;
              OP_CLEAR:                state <= S_CLR;
              default:                 state <= S_IDLE;
            endcase
          end
        end
        S_PUSH: begin
          DEPTH <= DEPTH + 3'd1;
          state <= S_IDLE;
        end
        S_POP_ISS: begin
          DEPTH <= DEPTH - 3'd1;
          state <= S_POP_DRN;
        end
        S_POP_DRN: begin
          if (op == OP_POP) begin
            OUT_DATA <= rd_q;
            state    <= S_EMIT;
          end else if (!second) begin
            a_q    <= rd_q;
            second <= 1'b1;
            state  <= S_POP_ISS;
          end else begin
            state <= S_PUSH;   // rd_q holds b until the push completes
          end
        end
        S_PEEK_ISS: state <= S_PEEK_DRN;
        S_PEEK_DRN: begin
          if (op == OP_DUP) begin
            state <= S_PUSH;
          end else begin
            OUT_DATA <= rd_q;
            state    <= S_EMIT;
          end
        end
        S_EMIT: if (OUT_READY) state <= S_IDLE;
        S_CLR: begin
          DEPTH <= 3'd0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // The stack drives the bus through the whole drain cycle; sampling at the
  // falling edge keeps clear of both the issue and the following command.
  always_ff @(negedge CLK) begin
    if (state == S_POP_DRN || state == S_PEEK_DRN) rd_q <= STK_DATA;
  end

  always_comb begin
    case (op)
      OP_PUSH: push_data = imm;
      OP_ADD:  push_data = rd_q + a_q;
      OP_SUB:  push_data = rd_q - a_q;   // b - a, b popped second
      default: push_data = rd_q;         // DUP re-pushes the peeked top
    endcase
  end

  always_comb begin
    STK_COMMAND = 2'b00;
    STK_INDEX   = 3'd0;
    case (state)
      S_PUSH:     STK_COMMAND = 2'b01;
      S_POP_ISS:  STK_COMMAND = 2'b10;
      S_POP_DRN:  STK_COMMAND = 2'b11;
      S_PEEK_ISS: begin STK_COMMAND = 2'b11; STK_INDEX = idx; end
      S_PEEK_DRN: begin STK_COMMAND = 2'b11; STK_INDEX = idx; end
      default:    STK_COMMAND = 2'b00;
    endcase
  end

  // Ready is withheld for the error-pulse cycle so the next accept lands
  // after the error has been reported.
  assign IN_READY  = !RESET && (state == S_IDLE) && !ERR;
  assign OUT_VALID = !RESET && (state == S_EMIT);
  assign STK_RESET = RESET || (state == S_CLR);
  assign STK_DATA  = (STK_COMMAND == 2'b01) ? push_data : 4'bzzzz;

endmodule

// File: tb/tb_stack_rpn_sequencer.sv
// Bench for stack_rpn_sequencer: a behavioural 5-entry stack sits on the
// STK_* bus, expected results and error codes are queued at issue time and a
// monitor pops and compares them whenever the DUT presents them.
module tb_stack_rpn_sequencer;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_instr;
  logic       in_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_ready;
  logic       err;
  logic [1:0] err_code;
  logic [2:0] depth;
  logic [1:0] stk_command;
  logic [2:0] stk_index;
  wire  [3:0] stk_data;
  logic       stk_reset;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_q[$];
  logic [1:0] err_q[$];

  stack_rpn_sequencer dut (
    .CLK(clk), .RESET(reset),
    .IN_VALID(in_valid), .IN_INSTR(in_instr), .IN_READY(in_ready),
    .OUT_VALID(out_valid), .OUT_DATA(out_data), .OUT_READY(out_ready),
    .ERR(err), .ERR_CODE(err_code), .DEPTH(depth),
    .STK_COMMAND(stk_command), .STK_INDEX(stk_index),
    .STK_DATA(stk_data), .STK_RESET(stk_reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stack: read commands load a data register that is driven
  // onto the bus while a read command is present.
  logic [3:0] mem [0:4];
  int         sp = 0;
  logic [3:0] rdreg = 4'd0;

  always @(posedge clk) begin
    if (stk_reset) begin
      sp    <= 0;
      rdreg <= 4'd0;
    end else begin
      case (stk_command)
        2'b01: if (sp < 5) begin
          mem[sp] <= stk_data;
          sp      <= sp + 1;
        end
        2'b10: if (sp > 0) begin
          rdreg <= mem[sp-1];
          sp    <= sp - 1;
        end
        2'b11: if (sp - 1 - int'(stk_index) >= 0) rdreg <= mem[sp-1-int'(stk_index)];
        default: ;
      endcase
    end
  end

  assign stk_data = stk_command[1] ? rdreg : 4'bzzzz;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor.
  logic [3:0] exp_d;
  logic [1:0] exp_c;
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL result_unexpected: got %0h expected none", out_data);
      end else begin
        exp_d = exp_q.pop_front();
        if (out_data !== exp_d) begin
          errors++;
          $display("FAIL result: got %0h expected %0h", out_data, exp_d);
        end
      end
    end
    if (err) begin
      checks++;
      if (err_q.size() == 0) begin
        errors++;
        $display("FAIL err_unexpected: got code %0d expected no error", err_code);
      end else begin
        exp_c = err_q.pop_front();
        if (err_code !== exp_c) begin
          errors++;
          $display("FAIL err_code: got %0d expected %0d", err_code, exp_c);
        end
      end
    end
  end

  // Offer an instruction at a falling edge once IN_READY is seen; it is
  // accepted at the next rising edge. Returns just after that edge (C1).
  task automatic send(input logic [7:0] ins);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready 0 expected 1");
    end
    in_valid = 1'b1;
    in_instr = ins;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got in_ready 0 expected 1");
    end
  endtask

  task automatic do_push(input logic [3:0] v);
    send({4'h1, v});
    wait_idle();
  endtask

  task automatic do_read(input logic [7:0] ins, input logic [3:0] v);
    exp_q.push_back(v);
    send(ins);
    wait_idle();
  endtask

  task automatic do_err(input logic [7:0] ins, input logic [1:0] code);
    err_q.push_back(code);
    send(ins);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    reset = 1'b1; in_valid = 1'b0; in_instr = 8'h00; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stk_reset", 8'(stk_reset), 8'd1);
    chk("rst_in_ready", 8'(in_ready), 8'd0);
    chk("rst_out_valid", 8'(out_valid), 8'd0);
    chk("rst_out_data", 8'(out_data), 8'd0);
    chk("rst_err", 8'(err), 8'd0);
    chk("rst_err_code", 8'(err_code), 8'd0);
    chk("rst_depth", 8'(depth), 8'd0);
    chk("rst_command", 8'(stk_command), 8'd0);
    chk("rst_index", 8'(stk_index), 8'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 8'(in_ready), 8'd1);
    chk("stk_reset_low", 8'(stk_reset), 8'd0);

    // PUSH 3, PUSH 9, POP with cycle-level checks
    send(8'h13);
    @(negedge clk);
    chk("push_c1_cmd", 8'(stk_command), 8'd1);
    chk("push_c1_data", 8'(stk_data), 8'd3);
    wait_idle();
    chk("depth_a1", 8'(depth), 8'd1);
    do_push(4'd9);
    chk("depth_a2", 8'(depth), 8'd2);
    exp_q.push_back(4'd9);
    send(8'h20);
    @(negedge clk);
    chk("pop_c1_cmd", 8'(stk_command), 8'd2);
    @(negedge clk);
    chk("pop_c2_cmd", 8'(stk_command), 8'd3);
    chk("pop_c2_idx", 8'(stk_index), 8'd0);
    @(negedge clk);
    chk("pop_c3_valid", 8'(out_valid), 8'd1);
    wait_idle();
    chk("depth_a3", 8'(depth), 8'd1);
    send(8'h70);
    @(negedge clk);
    chk("clr_stk_reset", 8'(stk_reset), 8'd1);
    chk("clr_cmd", 8'(stk_command), 8'd0);
    wait_idle();
    chk("clr_depth", 8'(depth), 8'd0);

    // PEEK
    do_push(4'd7); do_push(4'd4); do_push(4'd12);
    do_read(8'h32, 4'd7);
    chk("peek2_depth", 8'(depth), 8'd3);
    do_read(8'h30, 4'd12);
    chk("peek0_depth", 8'(depth), 8'd3);
    send(8'h70); wait_idle();

    // ADD / SUB
    do_push(4'd9); do_push(4'd11);
    send(8'h40); wait_idle();
    chk("add_depth", 8'(depth), 8'd1);
    do_read(8'h20, 4'd4);
    do_push(4'd2); do_push(4'd5);
    send(8'h50); wait_idle();
    chk("sub_depth", 8'(depth), 8'd1);
    do_read(8'h20, 4'd13);
    chk("arith_depth0", 8'(depth), 8'd0);

    // Overflow then drain to underflow
    for (int v = 1; v <= 5; v++) do_push(4'(v));
    err_q.push_back(2'b01);
    send(8'h16);
    @(negedge clk);
    chk("ovf_err_c1", 8'(err), 8'd1);
    @(negedge clk);
    chk("ovf_err_c2", 8'(err), 8'd0);
    chk("ovf_depth", 8'(depth), 8'd5);
    for (int v = 5; v >= 1; v--) do_read(8'h20, 4'(v));
    do_err(8'h20, 2'b10);
    chk("unf_depth", 8'(depth), 8'd0);
    chk("unf_code_held", 8'(err_code), 8'd2);

    // DUP, illegal opcode, bad peek index
    do_push(4'd6);
    send(8'h60); wait_idle();
    chk("dup_depth", 8'(depth), 8'd2);
    do_read(8'h20, 4'd6);
    do_read(8'h20, 4'd6);
    do_err(8'h60, 2'b10);
    do_err(8'h80, 2'b11);
    do_push(4'd1);
    do_err(8'h31, 2'b11);
    chk("badidx_depth", 8'(depth), 8'd1);
    send(8'h70); wait_idle();

    // Back-pressure on the result port
    do_push(4'd10);
    out_ready = 1'b0;
    exp_q.push_back(4'd10);
    send(8'h20);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_seen", 8'(out_valid), 8'd1);
    repeat (4) begin
      @(negedge clk);
      chk("bp_valid_held", 8'(out_valid), 8'd1);
      chk("bp_data_held", 8'(out_data), 8'd10);
      chk("bp_in_ready", 8'(in_ready), 8'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle_after", 8'(in_ready), 8'd1);

    // Reset during C3 of an ADD
    do_push(4'd3); do_push(4'd4);
    send(8'h40);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_stk_reset", 8'(stk_reset), 8'd1);
    chk("midrst_in_ready", 8'(in_ready), 8'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_cmd", 8'(stk_command), 8'd0);
      chk("abort_depth", 8'(depth), 8'd0);
      chk("abort_no_valid", 8'(out_valid), 8'd0);
    end

    // CLEAR at depth 3, then POP underflows
    do_push(4'd1); do_push(4'd2); do_push(4'd3);
    chk("pre_clear_depth", 8'(depth), 8'd3);
    send(8'h70); wait_idle();
    chk("clear3_depth", 8'(depth), 8'd0);
    do_err(8'h20, 2'b10);
    chk("clear_pop_code", 8'(err_code), 8'd2);

    repeat (5) @(negedge clk);
    chk("results_drained", 8'(exp_q.size()), 8'd0);
    chk("errors_drained", 8'(err_q.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
